alu_bus_responder: RTL and testbench
====================================

Name: alu_bus_responder

Overview:
Host-side responder for the 4-bit nibble ALU coprocessor protocol.
- Accepts one operation command at a time from a host.
- Presents the opcode and immediate to the ALU.
- Answers the ALU's bus read requests with operand values from a local 16x4 register file.
- Enables the ALU result, captures result and carry on the done strobe, and writes the result back.
- Sits between the host sequencer and the ALU pins (ALU ui_in/uo_out/uio).

Parameters:
TIMEOUT, 15, max cycles from issue to done before the op is aborted (1..31)
CNT_W, 5, width of the timeout counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  host command valid
cmd_ready  out  1  responder can accept a command (high only in IDLE)
cmd_op  in  4  1 ADDI, 2 ADD, 3 SUBI, 4 SUB, 5 NAND, 6 SHR
cmd_rs  in  4  first source register index
cmd_rt  in  4  second source register index (reg ops) or immediate (imm ops 1/3/6)
cmd_rd  in  4  destination register index
rsp_valid  out  1  one-cycle completion pulse
rsp_err  out  1  valid with rsp_valid: illegal op or timeout
rsp_data  out  4  captured result (0 on error)
rsp_carry  out  1  captured carry (0 on error)
wr_en  in  1  host register-file write
wr_addr  in  4  write index
wr_data  in  4  write data
rd_addr  in  4  host read index
rd_data  out  4  combinational rf[rd_addr]
alu_opcode  out  4  to ALU opcode pins
alu_mio  out  4  to ALU mio_in (immediate)
alu_bus_req  in  4  ALU request code
alu_bus_in  in  4  ALU shared bus, input path
alu_bus_out  out  4  shared bus, drive value
alu_bus_oe  out  4  shared bus, 4'b1111 when driving
alu_oe_n  out  1  ALU result output enable, active-low
alu_done  in  1  ALU done strobe
alu_carry  in  1  ALU carry

Behaviour:
- Reset values:
  - rf all 0; state IDLE.
  - alu_opcode=0, alu_mio=0, alu_bus_out=0, alu_bus_oe=0, alu_oe_n=1.
  - rsp_*=0; cmd_ready=1.
- Request codes: 4'b0001 = READ (drive next operand), 4'b0011 = NEXT (advance operand pointer), 0 = idle.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid with op outside 1..6: no ALU activity; next cycle rsp_valid=1, rsp_err=1; stay IDLE.
  - On cmd_valid with op in 1..6: latch op/rs/rt/rd; alu_opcode<=op; alu_mio<=cmd_rt for imm ops, else 0; ptr<=0, served<=0, cnt<=0; alu_oe_n<=0; go SERVE.
- SERVE (registered, one-cycle latency):
  - If alu_bus_req==READ: next cycle alu_bus_out<=(ptr? rf[rt] : rf[rs]), alu_bus_oe<=4'b1111, served<=1.
  - Otherwise alu_bus_oe<=0.
  - If alu_bus_req==NEXT and served==1: ptr<=1. NEXT before any READ leaves ptr=0, so imm ops read rs.
  - cnt increments each cycle.
- Completion: alu_done sampled high in SERVE →
  - rf[rd]<=alu_bus_in; rsp_data<=alu_bus_in, rsp_carry<=alu_carry.
  - rsp_valid=1, rsp_err=0 for one cycle.
  - alu_opcode<=0, alu_oe_n<=1, alu_bus_oe<=0; go IDLE.
  - alu_done is ignored outside SERVE.
- Timeout: cnt==TIMEOUT without done → rsp_valid=1, rsp_err=1, no writeback, alu_opcode<=0, alu_oe_n<=1, alu_bus_oe<=0; go IDLE.
- Bus contention rule: alu_bus_oe is never 1 in the cycle alu_done is sampled, nor in any cycle after a non-READ request.
- Host write port: wr_en is honoured in any state. Same-cycle collision with writeback to the same index: writeback wins. rd_data reflects writes next cycle.
- Reset mid-operation: all state clears immediately; alu_opcode=0 stops the ALU; no rsp_valid is emitted.
- rsp_valid and cmd_ready are never high in the same cycle as a SERVE→IDLE transition's successor command accept. A new command is accepted at the earliest the cycle after rsp_valid.

Test Plan:
- Preload r2=5; ADDI rs=2 imm(rt)=3 rd=4 against ALU model → alu_mio=3, bus driven 5 on READ, r4=8, rsp_carry=0, rsp_valid one cycle, rsp_err=0.
- r1=9, r2=9; ADD rs=1 rt=2 rd=7 → first READ drives 9 (rs), NEXT sets ptr, second READ drives 9 (rt); r7=2, rsp_carry=1.
- r5=5; SUBI rs=5 imm=7 rd=0 → r0=4'hE, rsp_carry=1; NAND r3=4'hC, r6=4'hA → 4'h7.
- cmd_op=9 → no alu_opcode change, rsp_err=1 next cycle. ALU model holds done low with TIMEOUT=15 → rsp_err=1 at cycle 15, rd unchanged, alu_opcode=0.
- wr_en to rd in the done cycle → writeback value survives. Host write to a non-target index mid-op → visible on rd_data next cycle.
- rst_n low during SERVE → alu_bus_oe=0, alu_opcode=0, alu_oe_n=1 immediately, rf cleared, no rsp_valid; a fresh ADD after reset completes normally.

Source files
------------

// File: rtl/alu_bus_responder_if.sv
// alu_bus_responder_if: host command/response and ALU pin bundle
interface alu_bus_responder_if;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_op, cmd_rs, cmd_rt, cmd_rd;
  logic       rsp_valid, rsp_err, rsp_carry;
  logic [3:0] rsp_data;
  logic [3:0] alu_opcode, alu_mio, alu_bus_req, alu_bus_in, alu_bus_out, alu_bus_oe;
  logic       alu_oe_n, alu_done, alu_carry;
  modport slave (
    input  cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd, alu_bus_req, alu_bus_in, alu_done, alu_carry,
    output cmd_ready, rsp_valid, rsp_err, rsp_data, rsp_carry,
           alu_opcode, alu_mio, alu_bus_out, alu_bus_oe, alu_oe_n
  );
  modport master (
    output cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd, alu_bus_req, alu_bus_in, alu_done, alu_carry,
    input  cmd_ready, rsp_valid, rsp_err, rsp_data, rsp_carry,
           alu_opcode, alu_mio, alu_bus_out, alu_bus_oe, alu_oe_n
  );
endinterface

// File: rtl/alu_bus_responder.sv
// alu_bus_responder: serves ALU operand reads from a 16x4 register file and writes results back
module alu_bus_responder #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_bus_responder_if.slave  bus,
  input  logic                wr_en,
  input  logic [3:0]          wr_addr,
  input  logic [3:0]          wr_data,
  input  logic [3:0]          rd_addr,
  output logic [3:0]          rd_data
);
  localparam logic [3:0] REQ_READ = 4'b0001;
  localparam logic [3:0] REQ_NEXT = 4'b0011;
  typedef enum logic {IDLE, SERVE} state_t;
  state_t state, state_nxt;
  logic [3:0] rf [16];
  logic [3:0] rs_r, rt_r, rd_r, oe_r;
  logic [CNT_W-1:0] cnt;
  logic ptr, served, accept, legal, imm, done_ev, to_ev;
  // no accept while a response is showing, so a new command lands the cycle after rsp_valid
  assign bus.cmd_ready = (state == IDLE) && !bus.rsp_valid;
  assign accept  = bus.cmd_valid && bus.cmd_ready;
  assign legal   = bus.cmd_op inside {[4'd1:4'd6]};
  assign imm     = bus.cmd_op inside {4'd1, 4'd3, 4'd6};
  assign done_ev = (state == SERVE) && bus.alu_done;
  assign to_ev   = (state == SERVE) && !bus.alu_done && (cnt == CNT_W'(TIMEOUT));
  // the ALU owns the bus while it strobes done
  assign bus.alu_bus_oe = oe_r & {4{~bus.alu_done}};
  assign rd_data = rf[rd_addr];
  always_comb
    state_nxt = (accept && legal) ? SERVE : (done_ev || to_ev) ? IDLE : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
      {rs_r, rt_r, rd_r, oe_r} <= '0;
      {ptr, served} <= '0;
      cnt <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_data    <= '0;
      bus.rsp_carry   <= 1'b0;
      bus.alu_opcode  <= '0;
      bus.alu_mio     <= '0;
      bus.alu_bus_out <= '0;
      bus.alu_oe_n    <= 1'b1;
    end else begin
      bus.rsp_valid <= 1'b0;
      if (wr_en) rf[wr_addr] <= wr_data;
      if (accept && !legal) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_err   <= 1'b1;
        bus.rsp_data  <= '0;
        bus.rsp_carry <= 1'b0;
      end
      if (accept && legal) begin
        rs_r <= bus.cmd_rs;
        rt_r <= bus.cmd_rt;
        rd_r <= bus.cmd_rd;
        bus.alu_opcode <= bus.cmd_op;
        bus.alu_mio    <= imm ? bus.cmd_rt : 4'd0;
        bus.alu_oe_n   <= 1'b0;
        {ptr, served}  <= '0;
        cnt <= '0;
      end
      if (state == SERVE) begin
        cnt  <= cnt + 1'b1;
        oe_r <= (bus.alu_bus_req == REQ_READ) ? 4'hF : 4'h0;
        if (bus.alu_bus_req == REQ_READ) begin
          bus.alu_bus_out <= ptr ? rf[rt_r] : rf[rs_r];
          served <= 1'b1;
        end
        if (bus.alu_bus_req == REQ_NEXT && served) ptr <= 1'b1;
        if (done_ev || to_ev) begin
          oe_r <= '0;
          bus.alu_opcode <= '0;
          bus.alu_oe_n   <= 1'b1;
          bus.rsp_valid  <= 1'b1;
          bus.rsp_err    <= to_ev;
          bus.rsp_data   <= done_ev ? bus.alu_bus_in : 4'd0;
          bus.rsp_carry  <= done_ev && bus.alu_carry;
        end
        if (done_ev) rf[rd_r] <= bus.alu_bus_in;
      end
    end
endmodule

// File: tb/tb_alu_bus_responder.sv
// tb_alu_bus_responder: directed table, corner sequences and random ops against a reference ALU/register model
module tb_alu_bus_responder;
  localparam int TIMEOUT = 15;
  localparam logic [3:0] READ = 4'b0001;
  localparam logic [3:0] NEXT = 4'b0011;
  typedef struct {
    logic [3:0] op, rs, rt, rd, pa, pb, exp_d;
    logic       exp_c;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0;
  logic [3:0] wr_addr = '0, wr_data = '0, rd_addr = '0, rd_data;
  logic [3:0] rf_m [16];
  int checks = 0, errors = 0;
  alu_bus_responder_if bus();
  alu_bus_responder #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic rdchk(input string name, input logic [3:0] addr, input logic [3:0] exp);
    rd_addr = addr;
    #1;
    chk(name, rd_data, exp);
  endtask
  task automatic wr(input logic [3:0] addr, input logic [3:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    tick;
    wr_en = 1'b0;
    rf_m[addr] = data;
  endtask
  function automatic bit is_imm(input logic [3:0] op);
    return op == 4'd1 || op == 4'd3 || op == 4'd6;
  endfunction
  // the ALU's arithmetic: carry is the add carry-out or the subtract borrow
  task automatic alu_ref(input logic [3:0] op, a, b, output logic [3:0] r, output logic c);
    logic [4:0] s;
    s = 5'(a) + 5'(b);
    r = 4'h0; c = 1'b0;
    if (op == 4'd1 || op == 4'd2) {c, r} = s;
    else if (op == 4'd3 || op == 4'd4) begin r = a - b; c = a < b; end
    else if (op == 4'd5) r = ~(a & b);
    else if (op == 4'd6) r = a >> b;
  endtask
  task automatic issue(input logic [3:0] op, rs, rt, rd);
    int n = 0;
    while (!bus.cmd_ready && n < 20) begin tick; n++; end
    chk("cmd_ready", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_rs = rs; bus.cmd_rt = rt; bus.cmd_rd = rd;
    tick;
    bus.cmd_valid = 1'b0;
  endtask
  // plays the ALU side: reads operands off the bus, computes, strobes done
  task automatic run_op(input logic [3:0] op, rs, rt, rd, input bit lead_next, input bit collide,
                        output logic [3:0] res, output logic c);
    logic [3:0] a, b;
    issue(op, rs, rt, rd);
    chk("alu_opcode", bus.alu_opcode, op);
    chk("alu_mio", bus.alu_mio, is_imm(op) ? rt : 4'd0);
    chk("alu_oe_n_on", bus.alu_oe_n, 0);
    if (lead_next) begin bus.alu_bus_req = NEXT; tick; end
    bus.alu_bus_req = READ;
    tick;
    chk("bus_oe_a", bus.alu_bus_oe, 4'hF);
    a = bus.alu_bus_out;
    chk("bus_a", a, rf_m[rs]);
    if (!is_imm(op)) begin
      bus.alu_bus_req = NEXT;
      tick;
      chk("bus_oe_next", bus.alu_bus_oe, 0);
      bus.alu_bus_req = READ;
      tick;
      b = bus.alu_bus_out;
      chk("bus_b", b, rf_m[rt]);
    end else b = bus.alu_mio;
    bus.alu_bus_req = 4'd0;
    tick;
    chk("bus_oe_idle", bus.alu_bus_oe, 0);
    alu_ref(op, a, b, res, c);
    bus.alu_bus_in = res; bus.alu_carry = c; bus.alu_done = 1'b1;
    if (collide) begin wr_en = 1'b1; wr_addr = rd; wr_data = ~res; end
    #1;
    chk("bus_oe_done", bus.alu_bus_oe, 0);
    tick;
    bus.alu_done = 1'b0; bus.alu_carry = 1'b0; wr_en = 1'b0;
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_err", bus.rsp_err, 0);
    chk("rsp_data", bus.rsp_data, res);
    chk("rsp_carry", bus.rsp_carry, c);
    chk("opcode_clr", bus.alu_opcode, 0);
    chk("oe_n_off", bus.alu_oe_n, 1);
    chk("ready_in_rsp", bus.cmd_ready, 0);
    rf_m[rd] = res;
    tick;
    chk("rsp_pulse", bus.rsp_valid, 0);
  endtask
  vec_t vecs [6];
  initial begin
    logic [3:0] res, er, a, b, op, rs, rt, rd;
    logic c, ec;
    int n;
    vecs[0] = '{op:4'd1, rs:4'd2,  rt:4'd3,  rd:4'd4,  pa:4'h5, pb:4'h0, exp_d:4'h8, exp_c:1'b0};
    vecs[1] = '{op:4'd2, rs:4'd1,  rt:4'd2,  rd:4'd7,  pa:4'h9, pb:4'h9, exp_d:4'h2, exp_c:1'b1};
    vecs[2] = '{op:4'd3, rs:4'd5,  rt:4'd7,  rd:4'd0,  pa:4'h5, pb:4'h0, exp_d:4'hE, exp_c:1'b1};
    vecs[3] = '{op:4'd5, rs:4'd3,  rt:4'd6,  rd:4'd1,  pa:4'hC, pb:4'hA, exp_d:4'h7, exp_c:1'b0};
    vecs[4] = '{op:4'd4, rs:4'd8,  rt:4'd9,  rd:4'd10, pa:4'h3, pb:4'h1, exp_d:4'h2, exp_c:1'b0};
    vecs[5] = '{op:4'd6, rs:4'd11, rt:4'd1,  rd:4'd12, pa:4'hB, pb:4'h0, exp_d:4'h5, exp_c:1'b0};
    for (int i = 0; i < 16; i++) rf_m[i] = 4'h0;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_rs = '0; bus.cmd_rt = '0; bus.cmd_rd = '0;
    bus.alu_bus_req = '0; bus.alu_bus_in = '0; bus.alu_done = 1'b0; bus.alu_carry = 1'b0;
    tick; tick;
    chk("rst_opcode", bus.alu_opcode, 0);
    chk("rst_mio", bus.alu_mio, 0);
    chk("rst_bus_out", bus.alu_bus_out, 0);
    chk("rst_bus_oe", bus.alu_bus_oe, 0);
    chk("rst_oe_n", bus.alu_oe_n, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    rst_n = 1'b1;
    tick;
    rdchk("rst_rf", 4'd7, 4'h0);
    for (int i = 0; i < 6; i++) begin
      wr(vecs[i].rs, vecs[i].pa);
      if (!is_imm(vecs[i].op)) wr(vecs[i].rt, vecs[i].pb);
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, 1'b0, 1'b0, res, c);
      chk("vec_data", res, vecs[i].exp_d);
      chk("vec_carry", c, vecs[i].exp_c);
      rdchk("vec_wb", vecs[i].rd, vecs[i].exp_d);
    end
    issue(4'd9, 4'd0, 4'd0, 4'd0);
    chk("bad_opcode", bus.alu_opcode, 0);
    chk("bad_oe_n", bus.alu_oe_n, 1);
    chk("bad_valid", bus.rsp_valid, 1);
    chk("bad_err", bus.rsp_err, 1);
    chk("bad_data", bus.rsp_data, 0);
    tick;
    chk("bad_pulse", bus.rsp_valid, 0);
    wr(4'd3, 4'h6);
    issue(4'd2, 4'd1, 4'd2, 4'd3);
    n = 0;
    while (!bus.rsp_valid && n < 40) begin
      if (n == 3) begin wr_en = 1'b1; wr_addr = 4'd15; wr_data = 4'hD; end
      else wr_en = 1'b0;
      tick;
      n++;
      if (n == 4) begin rf_m[15] = 4'hD; rdchk("mid_wr", 4'd15, 4'hD); end
    end
    wr_en = 1'b0;
    chk("timeout_cycles", 8'(n), 8'(TIMEOUT + 1));
    chk("to_err", bus.rsp_err, 1);
    chk("to_data", bus.rsp_data, 0);
    chk("to_carry", bus.rsp_carry, 0);
    chk("to_opcode", bus.alu_opcode, 0);
    chk("to_oe_n", bus.alu_oe_n, 1);
    rdchk("to_no_wb", 4'd3, 4'h6);
    tick;
    wr(4'd4, 4'h2); wr(4'd5, 4'h3);
    run_op(4'd2, 4'd4, 4'd5, 4'd6, 1'b0, 1'b1, res, c);
    rdchk("collide_wb", 4'd6, 4'h5);
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < int'($urandom_range(0, 3)); k++)
        wr(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      op = 4'($urandom_range(1, 6));
      rs = 4'($urandom_range(0, 15)); rt = 4'($urandom_range(0, 15)); rd = 4'($urandom_range(0, 15));
      a = rf_m[rs];
      b = is_imm(op) ? rt : rf_m[rt];
      alu_ref(op, a, b, er, ec);
      run_op(op, rs, rt, rd, 1'($urandom_range(0, 1)), i % 5 == 0, res, c);
      chk("rnd_data", res, er);
      chk("rnd_carry", c, ec);
      rdchk("rnd_wb", rd, er);
    end
    wr(4'd9, 4'h4);
    issue(4'd2, 4'd9, 4'd9, 4'd10);
    bus.alu_bus_req = READ;
    tick;
    chk("pre_rst_oe", bus.alu_bus_oe, 4'hF);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_oe", bus.alu_bus_oe, 0);
    chk("mid_rst_opcode", bus.alu_opcode, 0);
    chk("mid_rst_oe_n", bus.alu_oe_n, 1);
    for (int i = 0; i < 16; i++) rf_m[i] = 4'h0;
    rdchk("mid_rst_rf", 4'd9, 4'h0);
    bus.alu_bus_req = 4'd0;
    tick;
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    chk("post_rst_valid", bus.rsp_valid, 0);
    wr(4'd1, 4'h3); wr(4'd2, 4'h4);
    run_op(4'd2, 4'd1, 4'd2, 4'd5, 1'b0, 1'b0, res, c);
    chk("post_rst_res", res, 4'h7);
    rdchk("post_rst_wb", 4'd5, 4'h7);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
